// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the LSU arbiter and the load/store unit.
package lsu_arb_pkg;

  // Which master owns an in-flight access.
  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // One LSU access as presented by a master.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wren;
    logic [2:0]  op;
  } lsu_req_t;

  // Size codes understood by the LSU; the arbiter passes them through untouched.
  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  // Consecutive core grants tolerated while the debug master waits.
  localparam int unsigned DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/lsu_arbiter.sv
// Two-master arbiter and sequencer in front of the single-port LSU.
// Port C (core MEM stage) has fixed priority; a starvation counter forces a
// grant to port D (debug/loader) after STARVE_LIMIT core wins. Every grant
// goes through a registered issue stage and a response register, giving a
// fixed two-cycle grant-to-rvalid latency and in-order responses.
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // Core master
  input  logic        i_c_req,
  input  logic [31:0] i_c_addr,
  input  logic [31:0] i_c_wdata,
  input  logic        i_c_wren,
  input  logic [2:0]  i_c_op,
  output logic        o_c_gnt,
  output logic        o_c_rvalid,
  output logic [31:0] o_c_rdata,
  // Debug master
  input  logic        i_d_req,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic        i_d_wren,
  input  logic [2:0]  i_d_op,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  // LSU side
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_st_data,
  output logic        o_lsu_wren,
  output logic [2:0]  o_lsu_op,
  input  logic [31:0] i_lsu_ld_data
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_cnt;
  lsu_req_t         r_issue;
  logic             r_issue_valid;
  owner_e           r_issue_owner;
  logic             r_c_rvalid;
  logic             r_d_rvalid;
  logic [31:0]      r_c_rdata;
  logic [31:0]      r_d_rdata;

  logic             w_force_d;
  logic             w_c_gnt;
  logic             w_d_gnt;
  lsu_req_t         w_sel;
  logic [31:0]      w_rsp_data;

  // Arbitration: core wins unless the debug master has waited STARVE_LIMIT grants.
  always_comb begin
    w_force_d = (r_cnt == LIMIT);
    // NOTE: grants are masked by the asynchronous reset so no request is
    // accepted while the pipeline registers are being held clear.
    w_d_gnt   = ~i_reset & i_d_req & (~i_c_req | w_force_d);
    w_c_gnt   = ~i_reset & i_c_req & ~w_d_gnt;
    w_sel     = '{addr: i_c_addr, wdata: i_c_wdata, wren: i_c_wren, op: i_c_op};
    if (w_d_gnt) begin
      w_sel = '{addr: i_d_addr, wdata: i_d_wdata, wren: i_d_wren, op: i_d_op};
    end
  end

  // Starvation counter: counts core wins while D waits, saturating at the limit.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order blocks are evaluated in.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_d_gnt || !i_d_req) begin
      r_cnt <= '0;
    end else if (w_c_gnt && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Issue stage: capture the winning request; a bubble clears valid and wren
  // but leaves the address/data/op lines quiet at their last values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_issue       <= '0;
      r_issue_valid <= 1'b0;
      r_issue_owner <= OWN_C;
    end else if (w_c_gnt || w_d_gnt) begin
      r_issue       <= w_sel;
      r_issue_valid <= 1'b1;
      r_issue_owner <= w_d_gnt ? OWN_D : OWN_C;
    end else begin
      r_issue_valid <= 1'b0;
      r_issue.wren  <= 1'b0;
    end
  end

  // Store acks return zero; loads return the LSU's combinational read data.
  assign w_rsp_data = r_issue.wren ? 32'h0 : i_lsu_ld_data;

  // Response register: one-cycle rvalid pulse to the owner; the idle port's
  // rdata keeps its last value.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_c_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_c_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_c_rvalid <= r_issue_valid && (r_issue_owner == OWN_C);
      r_d_rvalid <= r_issue_valid && (r_issue_owner == OWN_D);
      if (r_issue_valid && (r_issue_owner == OWN_C)) r_c_rdata <= w_rsp_data;
      if (r_issue_valid && (r_issue_owner == OWN_D)) r_d_rdata <= w_rsp_data;
    end
  end

  assign o_c_gnt       = w_c_gnt;
  assign o_d_gnt       = w_d_gnt;
  assign o_c_rvalid    = r_c_rvalid;
  assign o_d_rvalid    = r_d_rvalid;
  assign o_c_rdata     = r_c_rdata;
  assign o_d_rdata     = r_d_rdata;
  assign o_lsu_addr    = r_issue.addr;
  assign o_lsu_st_data = r_issue.wdata;
  assign o_lsu_op      = r_issue.op;
  assign o_lsu_wren    = r_issue.wren & r_issue_valid;

endmodule
